// File: rtl/pa_rvfpm.sv
// Shared FPU-side types for the CORE-V-XIF result reorder/commit buffer.
package pa_rvfpm;

   localparam int unsigned XRB_FFLAGS_W = 5;

   typedef enum logic {
      XRB_IDLE,
      XRB_PRESENT
   } xrb_state_e;

   // Per-entry bookkeeping; id, data and fflags live in separate arrays
   // because their widths are set by the buffer's parameters.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       done;
      logic       committed;
      logic       killed;
   } xrb_entry_t;

endpackage

// File: rtl/xrb_id_cam.sv
// DEPTH-way id match over the valid entries of the result buffer.
// Returns a one-hot hit vector (ids are unique among valid entries) and a hit flag.
module xrb_id_cam #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned X_ID_WIDTH = 4
) (
   input  logic [DEPTH-1:0]                 entry_valid_i,
   input  logic [DEPTH-1:0][X_ID_WIDTH-1:0] entry_id_i,
   input  logic [X_ID_WIDTH-1:0]            lookup_id_i,
   output logic [DEPTH-1:0]                 hit_vec_o,
   output logic                             hit_o
);

   // Compare the lookup id against every valid entry.
   always_comb begin
      hit_vec_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec_o[i] = entry_valid_i[i] && (entry_id_i[i] == lookup_id_i);
      end
   end

   assign hit_o = |hit_vec_o;

endmodule

// File: rtl/xif_result_buffer.sv
// CORE-V-XIF result reorder/commit buffer: tracks accepted offloaded instructions by id,
// collects commit/kill and FPU results, and returns results in issue order after commit.
// Optional macro RVFPM_XIF_FFLAGS_EN adds per-entry fflags, result_fflags and a sticky
// fflags accumulator over retired beats.
module xif_result_buffer
   import pa_rvfpm::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned X_ID_WIDTH = 4,
   parameter int unsigned FLEN       = 32
) (
   input  logic                    ck,
   input  logic                    rst,
   input  logic                    alloc_valid,
   output logic                    alloc_ready,
   input  logic [X_ID_WIDTH-1:0]   alloc_id,
   input  logic [4:0]              alloc_rd,
   input  logic                    alloc_we,
   input  logic                    commit_valid,
   input  logic [X_ID_WIDTH-1:0]   commit_id,
   input  logic                    commit_kill,
   input  logic                    exe_valid,
   input  logic [X_ID_WIDTH-1:0]   exe_id,
   input  logic [FLEN-1:0]         exe_data,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [X_ID_WIDTH-1:0]   result_id,
   output logic [FLEN-1:0]         result_data,
   output logic [4:0]              result_rd,
   output logic                    result_we,
   output logic [$clog2(DEPTH):0]  count
`ifdef RVFPM_XIF_FFLAGS_EN
   ,
   input  logic [XRB_FFLAGS_W-1:0] exe_fflags,
   output logic [XRB_FFLAGS_W-1:0] result_fflags,
   output logic [XRB_FFLAGS_W-1:0] fflags_acc
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   xrb_entry_t                       ent_q  [DEPTH];
   xrb_entry_t                       ent_d  [DEPTH];
   logic [DEPTH-1:0][X_ID_WIDTH-1:0] id_q, id_d;
   logic [FLEN-1:0]                  data_q [DEPTH];
   logic [FLEN-1:0]                  data_d [DEPTH];
   logic [PTR_W-1:0]                 head_q, head_d;
   logic [PTR_W-1:0]                 tail_q, tail_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   xrb_state_e                       state_q, state_d;

   logic [X_ID_WIDTH-1:0]            res_id_q, res_id_d;
   logic [FLEN-1:0]                  res_data_q, res_data_d;
   logic [4:0]                       res_rd_q, res_rd_d;
   logic                             res_we_q, res_we_d;

`ifdef RVFPM_XIF_FFLAGS_EN
   logic [XRB_FFLAGS_W-1:0]          ff_q [DEPTH];
   logic [XRB_FFLAGS_W-1:0]          ff_d [DEPTH];
   logic [XRB_FFLAGS_W-1:0]          res_ff_q, res_ff_d;
   logic [XRB_FFLAGS_W-1:0]          acc_q, acc_d;
`endif

   logic                             alloc_fire;
   logic                             retire;
   xrb_entry_t                       head_ent;
   logic [DEPTH-1:0]                 cam_valid;
   logic [DEPTH-1:0][X_ID_WIDTH-1:0] cam_id;
   logic [DEPTH-1:0]                 exe_hit_vec, commit_hit_vec;
   logic                             exe_hit, commit_hit;

   // Ready depends only on the registered occupancy; a retire this cycle does not help.
   assign alloc_ready = (count_q < CNT_W'(DEPTH));
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign head_ent    = ent_q[head_q];

   // Lookup view includes the entry being allocated so a same-cycle commit lands on it.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         cam_valid[i] = ent_q[i].valid;
      end
      cam_id = id_q;
      if (alloc_fire) begin
         cam_valid[tail_q] = 1'b1;
         cam_id[tail_q]    = alloc_id;
      end
   end

   xrb_id_cam #(
      .DEPTH      (DEPTH),
      .X_ID_WIDTH (X_ID_WIDTH)
   ) u_exe_cam (
      .entry_valid_i (cam_valid),
      .entry_id_i    (cam_id),
      .lookup_id_i   (exe_id),
      .hit_vec_o     (exe_hit_vec),
      .hit_o         (exe_hit)
   );

   xrb_id_cam #(
      .DEPTH      (DEPTH),
      .X_ID_WIDTH (X_ID_WIDTH)
   ) u_commit_cam (
      .entry_valid_i (cam_valid),
      .entry_id_i    (cam_id),
      .lookup_id_i   (commit_id),
      .hit_vec_o     (commit_hit_vec),
      .hit_o         (commit_hit)
   );

   // Retire FSM: drop killed or silent heads, else present the head beat until accepted.
   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      res_id_d   = res_id_q;
      res_data_d = res_data_q;
      res_rd_d   = res_rd_q;
      res_we_d   = res_we_q;
`ifdef RVFPM_XIF_FFLAGS_EN
      res_ff_d   = res_ff_q;
      acc_d      = acc_q;
`endif
      case (state_q)
         XRB_IDLE: begin
            if (head_ent.valid) begin
               if (head_ent.killed) begin
                  retire = 1'b1;
               end else if (head_ent.committed && head_ent.done) begin
                  if (!head_ent.we) begin
                     retire = 1'b1;
                  end else begin
                     res_id_d   = id_q[head_q];
                     res_data_d = data_q[head_q];
                     res_rd_d   = head_ent.rd;
                     res_we_d   = head_ent.we;
`ifdef RVFPM_XIF_FFLAGS_EN
                     res_ff_d   = ff_q[head_q];
`endif
                     state_d    = XRB_PRESENT;
                  end
               end
            end
         end
         XRB_PRESENT: begin
            if (result_ready) begin
               retire  = 1'b1;
               state_d = XRB_IDLE;
`ifdef RVFPM_XIF_FFLAGS_EN
               acc_d   = acc_q | res_ff_q;
`endif
            end
         end
         default: state_d = XRB_IDLE;
      endcase
   end

   // Entry storage next state: allocate at tail, apply commit and exe, free the head.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i]  = ent_q[i];
         data_d[i] = data_q[i];
`ifdef RVFPM_XIF_FFLAGS_EN
         ff_d[i]   = ff_q[i];
`endif
      end
      id_d    = id_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire);

      if (alloc_fire) begin
         ent_d[tail_q] = '{valid: 1'b1, rd: alloc_rd, we: alloc_we, done: !alloc_we,
                           committed: 1'b0, killed: 1'b0};
         id_d[tail_q]  = alloc_id;
         tail_d        = ptr_inc(tail_q);
      end

      if (commit_valid && commit_hit) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_hit_vec[i]) begin
               ent_d[i].committed = !commit_kill;
               ent_d[i].killed    = commit_kill;
            end
         end
      end

      if (exe_valid && exe_hit) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (exe_hit_vec[i]) begin
               ent_d[i].done = 1'b1;
               data_d[i]     = exe_data;
`ifdef RVFPM_XIF_FFLAGS_EN
               ff_d[i]       = exe_fflags;
`endif
            end
         end
      end

      if (retire) begin
         ent_d[head_q].valid = 1'b0;
         head_d              = ptr_inc(head_q);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]  <= '0;
            data_q[i] <= '0;
`ifdef RVFPM_XIF_FFLAGS_EN
            ff_q[i]   <= '0;
`endif
         end
         id_q       <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         state_q    <= XRB_IDLE;
         res_id_q   <= '0;
         res_data_q <= '0;
         res_rd_q   <= '0;
         res_we_q   <= 1'b0;
`ifdef RVFPM_XIF_FFLAGS_EN
         res_ff_q   <= '0;
         acc_q      <= '0;
`endif
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]  <= ent_d[i];
            data_q[i] <= data_d[i];
`ifdef RVFPM_XIF_FFLAGS_EN
            ff_q[i]   <= ff_d[i];
`endif
         end
         id_q       <= id_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         state_q    <= state_d;
         res_id_q   <= res_id_d;
         res_data_q <= res_data_d;
         res_rd_q   <= res_rd_d;
         res_we_q   <= res_we_d;
`ifdef RVFPM_XIF_FFLAGS_EN
         res_ff_q   <= res_ff_d;
         acc_q      <= acc_d;
`endif
      end
   end

   assign result_valid = (state_q == XRB_PRESENT);
   assign result_id    = res_id_q;
   assign result_data  = res_data_q;
   assign result_rd    = res_rd_q;
   assign result_we    = res_we_q;
   assign count        = count_q;
`ifdef RVFPM_XIF_FFLAGS_EN
   assign result_fflags = res_ff_q;
   assign fflags_acc    = acc_q;
`endif

endmodule
